elastic_pipe_reg: RTL
=====================

ELASTIC_PIPE_REG -- requirements
Module: elastic_pipe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 105, meaning payload width in bits (PC 16 + EX 63 + MEM 18 + WB 8).
REQ-002 SHALL have parameter CLR_MASK, default all ones (DATA_W bits), meaning payload bits zeroed on flush; 0-bits keep their value.
REQ-003 SHALL have parameter CNT_W, default 16, meaning stall counter width (used only under ELASTIC_STALL_CNT_EN).
REQ-004 SHALL have port clk  in  1  system clock, rising edge; one clock domain.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  in  1  discard all held and incoming entries.
REQ-007 SHALL have port in_valid  in  1  upstream entry present.
REQ-008 SHALL have port in_ready  out  1  block accepts this cycle.
REQ-009 SHALL have port in_data  in  DATA_W  upstream payload.
REQ-010 SHALL have port out_valid  out  1  entry presented downstream.
REQ-011 SHALL have port out_ready  in  1  downstream accepts.
REQ-012 SHALL have port out_data  out  DATA_W  payload presented downstream.
REQ-013 SHALL have port stall_cnt  out  CNT_W  back-pressure cycle count (only with ELASTIC_STALL_CNT_EN).

Function
REQ-014 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready; both evaluated at the same rising edge.
REQ-015 SHALL be a 2-entry skid pipeline with main register (drives out_data) and skid register; states EMPTY, ONE, TWO.
REQ-016 out_valid SHALL be 1 in ONE and TWO; in_ready SHALL be 1 in EMPTY and ONE; both driven from state registers only (no combinational in->out path).
REQ-017 EMPTY: transfer in -> ONE, main <= in_data; otherwise hold.
REQ-018 ONE: in & out -> ONE, main <= in_data; in only -> TWO, skid <= in_data; out only -> EMPTY; neither -> hold.
REQ-019 TWO: transfer out -> ONE, main <= skid; otherwise hold; no input accepted.
REQ-020 Latency SHALL be 1 cycle from accepted input to out_valid; sustained throughput 1 entry/cycle while out_ready=1; order preserved.
REQ-021 Held payloads SHALL not change while not transferred (stall-stable).
REQ-022 flush=1 SHALL force state EMPTY next cycle, drop any simultaneous input and output transfer, and set main/skid bits where CLR_MASK=1 to 0; bits where CLR_MASK=0 keep value.
REQ-023 in_ready SHALL still reflect current state during a flush cycle; the input is discarded regardless.
REQ-024 rst has priority over flush; flush has priority over transfers.

Reset
REQ-025 On rst: state EMPTY, out_valid 0, in_ready 1 next cycle, main and skid all 0 (ignoring CLR_MASK), stall_cnt 0.
REQ-026 rst mid-operation SHALL discard both entries with no output transfer that cycle.

Configuration
REQ-027 Macro ELASTIC_STALL_CNT_EN defined: stall_cnt increments each cycle out_valid=1 & out_ready=0, saturates at all ones, cleared only by rst (not flush).
REQ-028 Macro undefined: stall_cnt port and counter logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package pipe_pkg SHALL hold state typedef (EMPTY/ONE/TWO) and default width constants (PC_W 16, EX_W 63, MEM_W 18, WB_W 8).
REQ-030 One sub-module pipe_data_reg (DATA_W-wide, wen, per-bit clear mask) SHALL implement main and skid registers.

Verification
REQ-031 Reset then in_valid=1, in_data=0x0ABC, out_ready=1 -> out_valid=1, out_data=0x0ABC next cycle; streaming 10 entries yields 10 outputs in order, one per cycle.
REQ-032 out_ready=0, push 0x1, 0x2 -> in_ready=0 after second; out_ready=1 -> 0x1 then 0x2 emitted, in_ready=1 again.
REQ-033 TWO state, flush=1 with CLR_MASK upper 16 bits=0, payload upper 16 = 0x1234 -> out_valid=0 next cycle, main upper 16 = 0x1234, rest 0.
REQ-034 rst and flush together in state ONE -> EMPTY, all payload bits 0.
REQ-035 ELASTIC_STALL_CNT_EN, CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 saturated; flush keeps 15; rst -> 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared state encoding and default payload field widths for the elastic pipeline register.
package pipe_pkg;

    localparam int PC_W  = 16;
    localparam int EX_W  = 63;
    localparam int MEM_W = 18;
    localparam int WB_W  = 8;
    localparam int PIPE_DATA_W = PC_W + EX_W + MEM_W + WB_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with write enable and a per-bit clear mask applied on flush.
module pipe_data_reg #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] CLR_MASK = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wen,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Reset clears everything; flush only clears the masked bits.
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= q & ~CLR_MASK;
        else if (wen)
            q <= d;
    end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Two-entry skid pipeline register; in_ready/out_valid come straight from state.
// Optional back-pressure counter enabled by defining ELASTIC_STALL_CNT_EN.
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = PIPE_DATA_W,
    parameter logic [DATA_W-1:0] CLR_MASK = '1,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef ELASTIC_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    pipe_state_e       state_q, state_d;
    logic              xfer_in, xfer_out;
    logic              main_wen, skid_wen;
    logic [DATA_W-1:0] main_d, skid_q;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign xfer_in   = in_valid & in_ready;
    assign xfer_out  = out_valid & out_ready;

    // Refill main from skid when draining TWO, otherwise from the input.
    assign main_d = (state_q == TWO) ? skid_q : in_data;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        main_wen = 1'b0;
        skid_wen = 1'b0;
        case (state_q)
            EMPTY: begin
                if (xfer_in) begin
                    state_d  = ONE;
                    main_wen = 1'b1;
                end
            end
            ONE: begin
                if (xfer_in && xfer_out) begin
                    main_wen = 1'b1;
                end else if (xfer_in) begin
                    state_d  = TWO;
                    skid_wen = 1'b1;
                end else if (xfer_out) begin
                    state_d  = EMPTY;
                end
            end
            TWO: begin
                if (xfer_out) begin
                    state_d  = ONE;
                    main_wen = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d  = EMPTY;
            main_wen = 1'b0;
            skid_wen = 1'b0;
        end
    end

    pipe_data_reg #(
        .DATA_W   (DATA_W),
        .CLR_MASK (CLR_MASK)
    ) u_main (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .wen (main_wen),
        .d   (main_d),
        .q   (out_data)
    );

    pipe_data_reg #(
        .DATA_W   (DATA_W),
        .CLR_MASK (CLR_MASK)
    ) u_skid (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .wen (skid_wen),
        .d   (in_data),
        .q   (skid_q)
    );

`ifdef ELASTIC_STALL_CNT_EN
    // Saturating; flush deliberately does not clear it.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end
`endif

endmodule
